x1_ioctl_loader: RTL and testbench

X1_IOCTL_LOADER -- requirements
Module: x1_ioctl_loader

---
 rtl/x1_ioctl_loader.sv | 136 +++++++++++++
 tb/tb_x1_ioctl_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x1_ioctl_loader.sv
// rtl/x1_ioctl_loader.sv - buffers matching ioctl download bytes through a small FIFO into a dpram write port
// Keeps a per-load checksum and byte count; out-of-range or overflowing bytes are dropped and flagged.
module x1_ioctl_loader #(
  parameter logic [7:0] INDEX = 8'h00,
  parameter int         AW    = 12,
  parameter int         DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          ram_req,
  input  logic          ram_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_wren,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic [7:0]    checksum,
  output logic [AW:0]   byte_count
);
  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [AW+7:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nx;
  logic [CW-1:0] r_count, r_live, w_count_nx, w_live_left;
  logic          r_dl_q, r_pend, r_ram_req, r_done, r_range_err;
  logic [AW-1:0] r_ram_addr;
  logic [7:0]    r_ram_data, r_checksum;
  logic [AW:0]   r_byte_count;
  logic          w_match, w_acc, w_inrange, w_full, w_push, w_err, w_pop;
  logic          w_rise, w_start, w_cur, w_active, w_req_nx;

  assign w_match     = ioctl_download && (ioctl_index == INDEX);
  assign w_acc       = w_match && ioctl_wr;
  assign w_inrange   = (ioctl_addr[24:AW] == '0);
  assign w_full      = (r_count == FULL);
  assign w_push      = w_acc && w_inrange && !w_full;
  assign w_err       = w_acc && (!w_inrange || w_full);
  assign w_pop       = r_ram_req && ram_gnt;
  assign w_rise      = w_match && !r_dl_q;
  assign w_start     = (r_state == S_IDLE) && (w_rise || r_pend);
  assign w_active    = (r_state == S_LOAD) || (r_state == S_DRAIN);
  // r_live counts only entries of the running load; a queued next file must not be written under it
  assign w_cur       = (r_state == S_LOAD) || ((r_state == S_DRAIN) && !r_pend && !w_rise);
  assign w_count_nx  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_live_left = r_live - CW'(w_pop);
  assign w_req_nx    = w_active && (w_live_left != '0);
  assign w_rd_nx     = r_rd_ptr + PW'(w_pop);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_LOAD;
      S_LOAD:  if (!ioctl_download) w_state_nx = S_DRAIN;
      S_DRAIN: if ((r_live == '0) && !r_ram_req) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dl_q       <= 1'b0;
      r_pend       <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_live       <= '0;
      r_ram_req    <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_done       <= 1'b0;
      r_range_err  <= 1'b0;
      r_checksum   <= '0;
      r_byte_count <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_dl_q    <= ioctl_download;
      r_count   <= w_count_nx;
      r_rd_ptr  <= w_rd_nx;
      r_ram_req <= w_req_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      // head is reloaded only when a request follows, so it holds while the grant is low
      if (w_req_nx) begin
        r_ram_addr <= r_mem[w_rd_nx][AW+7:8];
        r_ram_data <= r_mem[w_rd_nx][7:0];
      end
      if (w_start) begin
        r_live       <= w_count_nx;
        r_pend       <= 1'b0;
        r_done       <= 1'b0;
        r_range_err  <= w_err;
        r_checksum   <= '0;
        r_byte_count <= '0;
      end else begin
        r_live <= r_live + CW'(w_push && w_cur) - CW'(w_pop);
        if (w_rise && ((r_state == S_DRAIN) || (r_state == S_DONE))) r_pend <= 1'b1;
        if (w_err) r_range_err <= 1'b1;
        if (r_state == S_DONE) r_done <= !r_range_err;
        if (w_pop) begin
          r_checksum <= r_checksum + r_ram_data;
          if (r_byte_count != CNT_MAX) r_byte_count <= r_byte_count + 1'b1;
        end
      end
    end
  end

  assign ioctl_wait = (r_count >= WAIT_LVL);
  assign ram_req    = r_ram_req;
  assign ram_wren   = r_ram_req && ram_gnt;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign range_err  = r_range_err;
  assign checksum   = r_checksum;
  assign byte_count = r_byte_count;
endmodule

// File: tb/tb_x1_ioctl_loader.sv
// tb/tb_x1_ioctl_loader.sv - randomized self-checking bench for x1_ioctl_loader
module tb_x1_ioctl_loader;
  localparam logic [7:0] IDX   = 8'h02;
  localparam int         AW    = 12;
  localparam int         DEPTH = 4;
  localparam int         SPAN  = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_wren;
  logic          busy;
  logic          done;
  logic          range_err;
  logic [7:0]    checksum;
  logic [AW:0]   byte_count;

  x1_ioctl_loader #(.INDEX(IDX), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ram_req(ram_req),
    .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .range_err(range_err), .checksum(checksum),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          occ = 0;
  int          wait_bad = 0;
  int          wait_seen = 0;
  int          exp_sum = 0;
  int          exp_cnt = 0;
  bit          drv_done;
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int          wren_cyc[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  // item-level occupancy: accepted in-range strobes minus completed writes, drops when already full
  always @(negedge clk_sys) begin
    if (!reset_n) occ = 0;
    else begin
      if (ioctl_wait !== (occ >= DEPTH - 1)) wait_bad++;
      if (ioctl_wait === 1'b1) wait_seen++;
      if (ram_wren === 1'b1) begin
        obs_q.push_back({ram_addr, ram_data});
        wren_cyc.push_back(cyc);
      end
      if (ioctl_download && ioctl_index == IDX && ioctl_wr && ioctl_addr < 25'(SPAN) && occ < DEPTH) occ++;
      if (ram_wren === 1'b1) occ--;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic put(input logic [24:0] a, input logic [7:0] d, input bit honor);
    int g = 0;
    while (honor && ioctl_wait && g < 200) begin tick(1); g++; end
    if (g >= 200) chk("wait_stuck", ioctl_wait, 0);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic model_reset();
    exp_sum = 0; exp_cnt = 0;
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    exp_q.push_back({a[AW-1:0], d});
    exp_sum = (exp_sum + int'(d)) % 256;
    if (exp_cnt < SPAN) exp_cnt++;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    if (ioctl_download && ioctl_index == IDX && a < 25'(SPAN)) model_byte(a, d);
    put(a, d, 1'b1);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic dl_end();
    int g = 0;
    ioctl_download = 1'b0;
    tick(1);
    while (busy && g < 2000) begin tick(1); g++; end
    chk("load_end_busy", busy, 0);
  endtask

  task automatic check_writes(input string tag);
    int bad = 0;
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    chk({tag, "_order"}, bad, 0);
    obs_q.delete(); exp_q.delete(); wren_cyc.delete();
  endtask

  task automatic check_totals(input string tag, input logic exp_done);
    chk({tag, "_checksum"}, checksum, exp_sum);
    chk({tag, "_count"}, byte_count, exp_cnt);
    chk({tag, "_done"}, done, exp_done);
  endtask

  initial begin
    int start_c, lat, span, ws0, n;
    logic [7:0]  d;
    logic [24:0] a;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = IDX; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ram_gnt = 1'b1;
    tick(3);
    chk("rst_ctrl", {ioctl_wait, ram_req, ram_wren, busy, done, range_err}, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_addr_data", {ram_addr, ram_data}, 0);
    reset_n = 1'b1;
    tick(2);

    // 16 sequential bytes, grant always high
    model_reset();
    dl_start(IDX);
    start_c = cyc;
    for (int i = 0; i < 16; i++) send(25'(i), 8'(i + 1));
    dl_end();
    lat  = (wren_cyc.size() > 0) ? wren_cyc[0] - start_c : -1;
    span = (wren_cyc.size() >= 16) ? wren_cyc[15] - wren_cyc[0] : -1;
    chk("seq_latency", lat, 2);
    chk("seq_throughput", span, 15);
    check_writes("seq");
    chk("seq_checksum_0x88", checksum, 8'h88);
    check_totals("seq", 1'b1);
    chk("seq_range_err", range_err, 0);

    // grant dropped for 10 cycles mid-burst
    model_reset();
    ws0 = wait_seen;
    dl_start(IDX);
    fork
      for (int i = 0; i < 12; i++) send(25'($urandom_range(0, SPAN - 1)), 8'($urandom));
      begin tick(2 + $urandom_range(0, 2)); ram_gnt = 1'b0; tick(10); ram_gnt = 1'b1; end
    join
    dl_end();
    chk("gnt_low_wait_seen", wait_seen > ws0, 1);
    check_writes("gnt_low");
    check_totals("gnt_low", 1'b1);

    // out-of-range address
    model_reset();
    dl_start(IDX);
    send(25'h010, 8'($urandom));
    send(25'h1000, 8'h55);
    send(25'h011, 8'($urandom));
    dl_end();
    check_writes("oor");
    chk("oor_range_err", range_err, 1);
    check_totals("oor", 1'b0);

    // non-matching index is ignored entirely
    dl_start(8'h5A);
    for (int i = 0; i < 3; i++) send(25'(i), 8'($urandom));
    chk("badidx_busy", busy, 0);
    chk("badidx_wait", ioctl_wait, 0);
    dl_end();
    check_writes("badidx");
    chk("badidx_count_kept", byte_count, exp_cnt);
    chk("badidx_range_err_kept", range_err, 1);

    // overflow with grant low: source ignores wait
    model_reset();
    ram_gnt = 1'b0;
    dl_start(IDX);
    for (int i = 0; i < 6; i++) begin
      a = 25'($urandom_range(0, SPAN - 1)); d = 8'($urandom);
      if (i < DEPTH) model_byte(a, d);
      put(a, d, 1'b0);
    end
    tick(3);
    chk("ovf_range_err", range_err, 1);
    chk("ovf_hold_head", {ram_addr, ram_data}, exp_q[0]);
    chk("ovf_req_held", ram_req, 1);
    ram_gnt = 1'b1;
    dl_end();
    check_writes("ovf");
    check_totals("ovf", 1'b0);

    // reset with three bytes queued
    ram_gnt = 1'b0;
    dl_start(IDX);
    for (int i = 0; i < 3; i++) put(25'(i), 8'($urandom), 1'b1);
    tick(2);
    chk("rstq_req_before", ram_req, 1);
    reset_n = 1'b0; ioctl_download = 1'b0;
    #1;
    chk("rstq_req_now", ram_req, 0);
    chk("rstq_count", byte_count, 0);
    chk("rstq_wait", ioctl_wait, 0);
    tick(1);
    reset_n = 1'b1; ram_gnt = 1'b1;
    tick(20);
    chk("rstq_no_writes", obs_q.size(), 0);
    chk("rstq_busy", busy, 0);
    obs_q.delete(); exp_q.delete(); wren_cyc.delete();

    // back-to-back files, one idle cycle between them
    model_reset();
    dl_start(IDX);
    for (int i = 0; i < 5; i++) send(25'($urandom_range(0, SPAN - 1)), 8'($urandom));
    ioctl_download = 1'b0;
    tick(1);
    model_reset();
    ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) send(25'($urandom_range(0, SPAN - 1)), 8'($urandom));
    dl_end();
    check_writes("b2b");
    check_totals("b2b", 1'b1);

    // random loads with a random grant pattern and gaps
    for (int k = 0; k < 3; k++) begin
      model_reset();
      drv_done = 1'b0;
      dl_start(IDX);
      n = 8 + $urandom_range(0, 11);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            send(25'($urandom_range(0, SPAN - 1)), 8'($urandom));
            tick($urandom_range(0, 1));
          end
          drv_done = 1'b1;
        end
        begin
          while (!drv_done) begin ram_gnt = 1'($urandom); tick(1); end
          ram_gnt = 1'b1;
        end
      join
      dl_end();
      check_writes("rnd");
      check_totals("rnd", 1'b1);
    end

    // byte_count saturation past 2^AW bytes
    model_reset();
    dl_start(IDX);
    for (int i = 0; i < SPAN + 4; i++) send(25'(i % SPAN), 8'($urandom));
    dl_end();
    chk("sat_count_max", byte_count, SPAN);
    check_writes("sat");
    check_totals("sat", 1'b1);

    chk("wait_tracking", wait_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
